// File: rtl/jtcps_bus_pkg.sv
// Shared types, field widths and the region-match rule for the CPS 68000 bus controller.
package jtcps_bus_pkg;

  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned TOUT_W  = 8;
  localparam int unsigned HIT_W   = 3;
  localparam int unsigned MATCH_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } bus_st_t;

  // A region matches when every masked address bit equals its match bit
  function automatic logic region_match(input logic [MATCH_W-1:0] atop,
                                        input logic [MATCH_W-1:0] match,
                                        input logic [MATCH_W-1:0] mask);
    return ((atop ^ match) & mask) == '0;
  endfunction

endpackage

// File: rtl/jtcps_busctl_if.sv
// CPU-side bus bundle between the fx68k wrapper and the bus controller.
interface jtcps_busctl_if #(
  parameter int unsigned AW = 23,
  parameter int unsigned N  = 4
);
  logic                             cen;
  logic                             asn;
  logic                             bgackn;
  logic                             rnw;
  logic                             udsn;
  logic                             ldsn;
  logic [AW:1]                      a;
  logic [N-1:0]                     ok;
  logic [N-1:0]                     cs;
  logic [jtcps_bus_pkg::HIT_W-1:0]  hit;
  logic                             dtackn;
  logic                             berrn;

  modport master (
    output cen, asn, bgackn, rnw, udsn, ldsn, a, ok,
    input  cs, hit, dtackn, berrn
  );

  modport slave (
    input  cen, asn, bgackn, rnw, udsn, ldsn, a, ok,
    output cs, hit, dtackn, berrn
  );
endinterface

// File: rtl/jtcps_busctl_dec.sv
// Combinational priority decoder: top address bits to the lowest matching region index.
module jtcps_busctl_dec
  import jtcps_bus_pkg::*;
#(
  parameter int unsigned     N     = 4,
  parameter int unsigned     MB    = 8,
  parameter logic [N*MB-1:0] MATCH = '0,
  parameter logic [N*MB-1:0] MASK  = '0
) (
  input  logic [MB-1:0]    i_atop,
  output logic [HIT_W-1:0] o_hit_c,
  output logic             o_any_c
);

  // Scan from the top index down so the lowest matching index is the last write
  always_comb begin
    o_hit_c = '0;
    o_any_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (region_match(MATCH_W'(i_atop), MATCH_W'(MATCH[i*MB +: MB]),
                       MATCH_W'(MASK[i*MB +: MB]))) begin
        o_hit_c = HIT_W'(i);
        o_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcps_busctl.sv
// 68000 bus controller: region decode, registered chip selects, wait states,
// ok handshake and DTACKn generation. Optional bus-error timeout enabled by
// defining JTCPS_BUSTOUT_EN.
module jtcps_busctl
  import jtcps_bus_pkg::*;
#(
  parameter int unsigned         AW    = 23,
  parameter int unsigned         N     = 4,
  parameter int unsigned         MB    = 8,
  parameter logic [N*MB-1:0]     MATCH = '0,
  parameter logic [N*MB-1:0]     MASK  = '0,
  parameter logic [N*WAIT_W-1:0] WAIT  = '0,
  parameter logic [N-1:0]        USEOK = '0,
  parameter logic [TOUT_W-1:0]   TOUT  = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  jtcps_busctl_if.slave bus
);

  bus_st_t            r_st, w_st_nx;
  logic               r_armed, w_armed_nx;
  logic [WAIT_W-1:0]  r_wcnt, w_wcnt_nx;
  logic [HIT_W-1:0]   r_hit, w_hit_nx;
  logic               r_rnw, w_rnw_nx;
  logic [N-1:0]       r_cs, w_cs_nx;
  logic               r_dtackn, w_dtackn_nx;
`ifdef JTCPS_BUSTOUT_EN
  logic [TOUT_W-1:0]  r_tcnt, w_tcnt_nx;
  logic               r_berrn, w_berrn_nx;
`endif

  logic [HIT_W-1:0]   w_dec_hit;
  logic               w_dec_any;
  logic [WAIT_W-1:0]  w_wait_ld;
  logic               w_useok;
  logic               w_ok;
  logic [N-1:0]       w_hot;
  logic               w_strobe;
  logic               w_unused;

  jtcps_busctl_dec #(
    .N     (N),
    .MB    (MB),
    .MATCH (MATCH),
    .MASK  (MASK)
  ) u_dec (
    .i_atop  (bus.a[AW:AW-MB+1]),
    .o_hit_c (w_dec_hit),
    .o_any_c (w_dec_any)
  );

  assign w_strobe = ~(bus.udsn & bus.ldsn);
  assign w_unused = ^{bus.a, TOUT};

  // Per-region parameter and ok selection for the decoded and the latched region
  always_comb begin
    w_wait_ld = '0;
    w_useok   = 1'b0;
    w_ok      = 1'b0;
    w_hot     = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_dec_hit == HIT_W'(i)) w_wait_ld = WAIT[i*WAIT_W +: WAIT_W];
      if (r_hit == HIT_W'(i)) begin
        w_useok  = USEOK[i];
        w_ok     = bus.ok[i];
        w_hot[i] = 1'b1;
      end
    end
  end

  // Next-state and registered outputs; nothing moves outside cen
  always_comb begin
    w_st_nx     = r_st;
    w_armed_nx  = r_armed;
    w_wcnt_nx   = r_wcnt;
    w_hit_nx    = r_hit;
    w_rnw_nx    = r_rnw;
    w_cs_nx     = r_cs;
    w_dtackn_nx = r_dtackn;
`ifdef JTCPS_BUSTOUT_EN
    w_tcnt_nx   = r_tcnt;
    w_berrn_nx  = r_berrn;
`endif
    if (bus.cen) begin
      case (r_st)
        ST_IDLE: begin
          if (bus.asn) begin
            w_armed_nx = 1'b1;
          end else if (r_armed && bus.bgackn) begin
            w_armed_nx = 1'b0;
            w_hit_nx   = w_dec_hit;
            w_rnw_nx   = bus.rnw;
            w_wcnt_nx  = w_wait_ld;
`ifdef JTCPS_BUSTOUT_EN
            w_tcnt_nx  = '0;
`endif
            if (w_dec_any) begin
              w_st_nx = ST_WAIT;
            end else begin
              w_st_nx     = ST_ACK;
              w_dtackn_nx = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (bus.asn) begin
            w_st_nx  = ST_IDLE;
            w_cs_nx  = '0;
            w_hit_nx = '0;
          end else begin
            // Writes hold off the chip select until a data strobe is low
            if (r_rnw || w_strobe) w_cs_nx = w_hot;
            if (r_wcnt != '0) w_wcnt_nx = r_wcnt - WAIT_W'(1);
            if (r_wcnt == '0 && (!w_useok || w_ok)) begin
              w_st_nx     = ST_ACK;
              w_dtackn_nx = 1'b0;
            end
`ifdef JTCPS_BUSTOUT_EN
            else if (r_tcnt == TOUT) begin
              w_st_nx    = ST_ERR;
              w_cs_nx    = '0;
              w_hit_nx   = '0;
              w_berrn_nx = 1'b0;
            end else begin
              w_tcnt_nx = r_tcnt + TOUT_W'(1);
            end
`endif
          end
        end
        ST_ACK: begin
          if (bus.asn) begin
            w_st_nx     = ST_IDLE;
            w_cs_nx     = '0;
            w_hit_nx    = '0;
            w_dtackn_nx = 1'b1;
          end
        end
        ST_ERR: begin
          if (bus.asn) begin
            w_st_nx = ST_IDLE;
`ifdef JTCPS_BUSTOUT_EN
            w_berrn_nx = 1'b1;
`endif
          end
        end
        default: w_st_nx = ST_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= ST_IDLE;
      r_armed  <= 1'b0;
      r_wcnt   <= '0;
      r_hit    <= '0;
      r_rnw    <= 1'b1;
      r_cs     <= '0;
      r_dtackn <= 1'b1;
`ifdef JTCPS_BUSTOUT_EN
      r_tcnt   <= '0;
      r_berrn  <= 1'b1;
`endif
    end else begin
      r_st     <= w_st_nx;
      r_armed  <= w_armed_nx;
      r_wcnt   <= w_wcnt_nx;
      r_hit    <= w_hit_nx;
      r_rnw    <= w_rnw_nx;
      r_cs     <= w_cs_nx;
      r_dtackn <= w_dtackn_nx;
`ifdef JTCPS_BUSTOUT_EN
      r_tcnt   <= w_tcnt_nx;
      r_berrn  <= w_berrn_nx;
`endif
    end
  end

  assign bus.cs     = r_cs;
  assign bus.hit    = r_hit;
  assign bus.dtackn = r_dtackn | bus.asn;
`ifdef JTCPS_BUSTOUT_EN
  assign bus.berrn  = r_berrn;
`else
  assign bus.berrn  = 1'b1;
`endif

endmodule
